stage_rr: RTL and testbench

Register-read / operand-fetch stage of the br32 pipeline. It reads the architectural register file and compare register that the writeback stage updates, resolves RAW hazards by forwarding from EX, MEM and WB, and inserts load-use bubbles. It latches resolved operands into the ID→EX pipeline register and drives a stall back to fetch/decode.

---
 rtl/br32_pkg.sv | 27 ++
 rtl/stage_rr_if.sv | 15 +
 rtl/rr_fwd_mux.sv | 51 +++++
 rtl/stage_rr.sv | 132 +++++++++++++
 tb/tb_stage_rr.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/br32_pkg.sv
// Shared br32 pipeline types: forwarding-source selector, the zero register
// specifier, and the layout of the ID->EX pipeline register.
package br32_pkg;

  typedef enum logic [2:0] {
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF,
    FWD_ZERO
  } fwd_src_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  cr;
    logic [4:0]  rd;
    logic        w_rd;
    logic        w_cr;
    logic        is_load;
    logic        bubble;
  } rr_out_t;

endpackage

// File: rtl/stage_rr_if.sv
// ID->EX pipeline register bundle: the register-read stage drives it, EX consumes it.
interface stage_rr_if;
  logic [31:0] pc;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  cr;
  logic [4:0]  rd;
  logic        w_rd;
  logic        w_cr;
  logic        is_load;
  logic        bubble;

  modport master (output pc, a, b, cr, rd, w_rd, w_cr, is_load, bubble);
  modport slave  (input  pc, a, b, cr, rd, w_rd, w_cr, is_load, bubble);
endinterface

// File: rtl/rr_fwd_mux.sv
// Resolves one source operand: r0, then EX/MEM/WB forwarding, then the regfile.
// A load in EX that matches is reported as a hazard and is never forwarded.
module rr_fwd_mux
  import br32_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [4:0]  ex_rd,
  input  logic        ex_w_rd,
  input  logic        ex_is_load,
  input  logic        ex_bubble,
  input  logic [31:0] ex_res,
  input  logic [4:0]  mem_rd,
  input  logic        mem_w_rd,
  input  logic        mem_bubble,
  input  logic [31:0] mem_res,
  input  logic [4:0]  wb_rd,
  input  logic        wb_w_rd,
  input  logic [31:0] wb_res,
  input  logic [31:0] regs [32],
  output logic [31:0] value,
  output logic        is_load_hit
);

  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;
  fwd_src_e sel;

  always_comb begin
    ex_hit      = !ex_bubble && ex_w_rd && (ex_rd == src) && (src != REG_ZERO);
    mem_hit     = !mem_bubble && mem_w_rd && (mem_rd == src) && (src != REG_ZERO);
    wb_hit      = wb_w_rd && (wb_rd == src) && (src != REG_ZERO);
    is_load_hit = ex_hit && ex_is_load;

    // A loading EX producer falls through so an unused operand still gets a defined value.
    if (src == REG_ZERO)            sel = FWD_ZERO;
    else if (ex_hit && !ex_is_load) sel = FWD_EX;
    else if (mem_hit)               sel = FWD_MEM;
    else if (wb_hit)                sel = FWD_WB;
    else                            sel = FWD_RF;

    case (sel)
      FWD_EX:  value = ex_res;
      FWD_MEM: value = mem_res;
      FWD_WB:  value = wb_res;
      FWD_RF:  value = regs[src];
      default: value = 32'd0;
    endcase
  end

endmodule

// File: rtl/stage_rr.sv
// br32 register-read stage: operand fetch with forwarding, load-use bubble
// insertion, and the ID->EX pipeline register.
module stage_rr
  import br32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_use_cr,
  input  logic        id_w_rd,
  input  logic        id_w_cr,
  input  logic        id_is_load,
  input  logic        id_bubble,
  input  logic [4:0]  ex_rd,
  input  logic        ex_w_rd,
  input  logic        ex_w_cr,
  input  logic        ex_is_load,
  input  logic        ex_bubble,
  input  logic [31:0] ex_res,
  input  logic [1:0]  ex_cmp_res,
  input  logic [4:0]  mem_rd,
  input  logic        mem_w_rd,
  input  logic        mem_w_cr,
  input  logic        mem_bubble,
  input  logic [31:0] mem_res,
  input  logic [1:0]  mem_cmp_res,
  input  logic [4:0]  wb_rd,
  input  logic        wb_w_rd,
  input  logic [31:0] wb_res,
  input  logic [31:0] regs [32],
  input  logic [1:0]  cmp_reg,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  stage_rr_if.master  rr
);

  logic [4:0]  src       [2];
  logic [31:0] opnd      [2];
  logic        load_hit  [2];
  logic        use_src   [2];
  logic [1:0]  cr_resolved;
  logic        luh;
  rr_out_t     rr_reg;
  rr_out_t     rr_next;

  // The compare register is always latched, so its use flag carries no logic here.
  logic unused_use_cr;
  assign unused_use_cr = id_use_cr;

  assign src[0]     = id_rs1;
  assign src[1]     = id_rs2;
  assign use_src[0] = id_use_rs1;
  assign use_src[1] = id_use_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      rr_fwd_mux u_mux (
        .src        (src[gi]),
        .ex_rd      (ex_rd),
        .ex_w_rd    (ex_w_rd),
        .ex_is_load (ex_is_load),
        .ex_bubble  (ex_bubble),
        .ex_res     (ex_res),
        .mem_rd     (mem_rd),
        .mem_w_rd   (mem_w_rd),
        .mem_bubble (mem_bubble),
        .mem_res    (mem_res),
        .wb_rd      (wb_rd),
        .wb_w_rd    (wb_w_rd),
        .wb_res     (wb_res),
        .regs       (regs),
        .value      (opnd[gi]),
        .is_load_hit(load_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    if (!ex_bubble && ex_w_cr)        cr_resolved = ex_cmp_res;
    else if (!mem_bubble && mem_w_cr) cr_resolved = mem_cmp_res;
    else                              cr_resolved = cmp_reg;
  end

  assign luh   = !id_bubble && ((use_src[0] && load_hit[0]) || (use_src[1] && load_hit[1]));
  assign stall = (hold || luh) && !flush;

  always_comb begin
    rr_next = rr_reg;
    if (flush || (!hold && luh)) begin
      rr_next.bubble = 1'b1;
      rr_next.w_rd   = 1'b0;
      rr_next.w_cr   = 1'b0;
    end else if (!hold) begin
      rr_next.pc      = id_pc;
      rr_next.a       = opnd[0];
      rr_next.b       = opnd[1];
      rr_next.cr      = cr_resolved;
      rr_next.rd      = id_rd;
      rr_next.w_rd    = id_w_rd && !id_bubble;
      rr_next.w_cr    = id_w_cr && !id_bubble;
      rr_next.is_load = id_is_load;
      rr_next.bubble  = id_bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg        <= '0;
      rr_reg.bubble <= 1'b1;
    end else begin
      rr_reg <= rr_next;
    end
  end

  assign rr.pc      = rr_reg.pc;
  assign rr.a       = rr_reg.a;
  assign rr.b       = rr_reg.b;
  assign rr.cr      = rr_reg.cr;
  assign rr.rd      = rr_reg.rd;
  assign rr.w_rd    = rr_reg.w_rd;
  assign rr.w_cr    = rr_reg.w_cr;
  assign rr.is_load = rr_reg.is_load;
  assign rr.bubble  = rr_reg.bubble;

endmodule

// File: tb/tb_stage_rr.sv
// Directed bench for stage_rr: a vector table for single-cycle resolution plus
// hand-written sequences for load-use, hold, flush priority and reset.
module tb_stage_rr;
  import br32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_use_cr;
  logic        id_w_rd, id_w_cr, id_is_load, id_bubble;
  logic [4:0]  ex_rd;
  logic        ex_w_rd, ex_w_cr, ex_is_load, ex_bubble;
  logic [31:0] ex_res;
  logic [1:0]  ex_cmp_res;
  logic [4:0]  mem_rd;
  logic        mem_w_rd, mem_w_cr, mem_bubble;
  logic [31:0] mem_res;
  logic [1:0]  mem_cmp_res;
  logic [4:0]  wb_rd;
  logic        wb_w_rd;
  logic [31:0] wb_res;
  logic [31:0] regs [32];
  logic [1:0]  cmp_reg;
  logic        flush, hold, stall;

  stage_rr_if rr_if ();

  stage_rr dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_cr(id_use_cr),
    .id_w_rd(id_w_rd), .id_w_cr(id_w_cr), .id_is_load(id_is_load), .id_bubble(id_bubble),
    .ex_rd(ex_rd), .ex_w_rd(ex_w_rd), .ex_w_cr(ex_w_cr), .ex_is_load(ex_is_load),
    .ex_bubble(ex_bubble), .ex_res(ex_res), .ex_cmp_res(ex_cmp_res),
    .mem_rd(mem_rd), .mem_w_rd(mem_w_rd), .mem_w_cr(mem_w_cr), .mem_bubble(mem_bubble),
    .mem_res(mem_res), .mem_cmp_res(mem_cmp_res),
    .wb_rd(wb_rd), .wb_w_rd(wb_w_rd), .wb_res(wb_res),
    .regs(regs), .cmp_reg(cmp_reg), .flush(flush), .hold(hold),
    .stall(stall), .rr(rr_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use1, use2, id_bub;
    logic [4:0]  ex_rd;
    logic        ex_w, ex_ld, ex_bub, ex_wcr;
    logic [31:0] ex_res;
    logic [1:0]  ex_cr;
    logic [4:0]  mem_rd;
    logic        mem_w, mem_bub, mem_wcr;
    logic [31:0] mem_res;
    logic [1:0]  mem_cr;
    logic [4:0]  wb_rd;
    logic        wb_w;
    logic [31:0] wb_res;
    logic [1:0]  cmp;
    logic        e_stall, e_bub;
    logic [31:0] e_a, e_b;
    logic [1:0]  e_cr;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vec [NVEC];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.use1 = 1'b1; v.use2 = 1'b1; v.id_bub = 1'b0;
    v.ex_rd = 5'd0; v.ex_w = 1'b0; v.ex_ld = 1'b0; v.ex_bub = 1'b1; v.ex_wcr = 1'b0;
    v.ex_res = 32'd0; v.ex_cr = 2'b00;
    v.mem_rd = 5'd0; v.mem_w = 1'b0; v.mem_bub = 1'b1; v.mem_wcr = 1'b0;
    v.mem_res = 32'd0; v.mem_cr = 2'b00;
    v.wb_rd = 5'd0; v.wb_w = 1'b0; v.wb_res = 32'd0; v.cmp = 2'b00;
    v.e_stall = 1'b0; v.e_bub = 1'b0; v.e_a = 32'h1001; v.e_b = 32'h1002; v.e_cr = 2'b00;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    id_bubble = v.id_bub; id_rd = 5'd10; id_w_rd = 1'b1; id_w_cr = 1'b1;
    id_is_load = 1'b0; id_use_cr = 1'b1;
    ex_rd = v.ex_rd; ex_w_rd = v.ex_w; ex_is_load = v.ex_ld; ex_bubble = v.ex_bub;
    ex_w_cr = v.ex_wcr; ex_res = v.ex_res; ex_cmp_res = v.ex_cr;
    mem_rd = v.mem_rd; mem_w_rd = v.mem_w; mem_bubble = v.mem_bub;
    mem_w_cr = v.mem_wcr; mem_res = v.mem_res; mem_cmp_res = v.mem_cr;
    wb_rd = v.wb_rd; wb_w_rd = v.wb_w; wb_res = v.wb_res; cmp_reg = v.cmp;
    flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] held_a, held_pc;

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[3] = 32'h1234;

    // Plain regfile read
    v = dflt(); v.rs1 = 5'd3; v.e_a = 32'h1234; vec[0] = v;
    // Forward priority EX > MEM > WB
    v = dflt(); v.rs1 = 5'd5;
    v.ex_rd = 5'd5; v.ex_w = 1; v.ex_bub = 0; v.ex_res = 32'hA;
    v.mem_rd = 5'd5; v.mem_w = 1; v.mem_bub = 0; v.mem_res = 32'hB;
    v.wb_rd = 5'd5; v.wb_w = 1; v.wb_res = 32'hC; v.e_a = 32'hA; vec[1] = v;
    v.ex_w = 0; v.e_a = 32'hB; vec[2] = v;
    v.mem_w = 0; v.e_a = 32'hC; vec[3] = v;
    // r0 never forwards and never reads the regfile
    v = dflt(); v.rs2 = 5'd0; v.ex_rd = 5'd0; v.ex_w = 1; v.ex_bub = 0; v.ex_res = 32'hFF;
    v.e_b = 32'h0; vec[4] = v;
    // Bubbled MEM producer is ignored
    v = dflt(); v.rs1 = 5'd7; v.mem_rd = 5'd7; v.mem_w = 1; v.mem_bub = 1; v.mem_res = 32'hDEAD;
    v.e_a = 32'h1007; vec[5] = v;
    // Compare register forwarding
    v = dflt(); v.mem_bub = 0; v.mem_wcr = 1; v.mem_cr = 2'b10; v.e_cr = 2'b10; vec[6] = v;
    v.ex_bub = 0; v.ex_wcr = 1; v.ex_cr = 2'b01; v.e_cr = 2'b01; vec[7] = v;
    v = dflt(); v.cmp = 2'b11; v.mem_wcr = 1; v.mem_cr = 2'b10; v.e_cr = 2'b11; vec[8] = v;
    // Independent MEM and WB forwards on the two sources
    v = dflt(); v.rs1 = 5'd4; v.rs2 = 5'd6;
    v.mem_rd = 5'd4; v.mem_w = 1; v.mem_bub = 0; v.mem_res = 32'h44;
    v.wb_rd = 5'd6; v.wb_w = 1; v.wb_res = 32'h66; v.e_a = 32'h44; v.e_b = 32'h66; vec[9] = v;
    // Load in EX on an unused operand: no stall, regfile value latched
    v = dflt(); v.rs2 = 5'd9; v.use2 = 0; v.ex_rd = 5'd9; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    v.ex_res = 32'hBAD; v.e_b = 32'h1009; vec[10] = v;
    // Load-use on rs1
    v = dflt(); v.rs1 = 5'd8; v.ex_rd = 5'd8; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    v.e_stall = 1; v.e_bub = 1; vec[11] = v;
    // Load to r0 is no hazard
    v = dflt(); v.rs1 = 5'd0; v.ex_rd = 5'd0; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    v.e_a = 32'h0; vec[12] = v;
    // Empty ID slot never stalls and latches a bubble without writes
    v = dflt(); v.id_bub = 1; v.rs1 = 5'd8; v.ex_rd = 5'd8; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    v.e_bub = 1; vec[13] = v;

    // Reset state
    apply(dflt());
    id_pc = 32'h0; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_bubble", 32'(rr_if.bubble), 32'd1);
    chk("reset_w_rd", 32'(rr_if.w_rd), 32'd0);
    chk("reset_a", rr_if.a, 32'd0);
    chk("reset_pc", rr_if.pc, 32'd0);
    $display("reset: bubble=%0d a=0x%08h", rr_if.bubble, rr_if.a);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(vec[i]);
      id_pc = 32'h100 + 32'(i * 4);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vec[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_bubble", i), 32'(rr_if.bubble), 32'(vec[i].e_bub));
      chk($sformatf("vec%0d_w_rd", i), 32'(rr_if.w_rd), 32'(!vec[i].e_bub));
      chk($sformatf("vec%0d_w_cr", i), 32'(rr_if.w_cr), 32'(!vec[i].e_bub));
      if (!vec[i].e_bub) begin
        chk($sformatf("vec%0d_a", i), rr_if.a, vec[i].e_a);
        chk($sformatf("vec%0d_b", i), rr_if.b, vec[i].e_b);
        chk($sformatf("vec%0d_cr", i), 32'(rr_if.cr), 32'(vec[i].e_cr));
        chk($sformatf("vec%0d_pc", i), rr_if.pc, 32'h100 + 32'(i * 4));
      end
      $display("vec %0d: stall=%0d bubble=%0d a=0x%08h b=0x%08h cr=%0b",
               i, stall, rr_if.bubble, rr_if.a, rr_if.b, rr_if.cr);
      @(negedge clk);
    end

    // Load-use then MEM forward on the following cycle
    v = dflt(); v.rs2 = 5'd9; v.ex_rd = 5'd9; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    apply(v); id_pc = 32'h200; #1;
    chk("luh_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("luh_bubble", 32'(rr_if.bubble), 32'd1);
    chk("luh_w_rd", 32'(rr_if.w_rd), 32'd0);
    $display("load-use: bubble=%0d w_rd=%0d", rr_if.bubble, rr_if.w_rd);
    @(negedge clk);
    v = dflt(); v.rs2 = 5'd9; v.mem_rd = 5'd9; v.mem_w = 1; v.mem_bub = 0; v.mem_res = 32'h55;
    apply(v); id_pc = 32'h200; #1;
    chk("luh_next_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("luh_next_b", rr_if.b, 32'h55);
    chk("luh_next_bubble", 32'(rr_if.bubble), 32'd0);
    $display("load-use retry: b=0x%08h bubble=%0d", rr_if.b, rr_if.bubble);
    @(negedge clk);

    // Hold freezes the register for three cycles
    v = dflt(); v.rs1 = 5'd3; apply(v); id_pc = 32'h300;
    @(posedge clk); #1;
    held_a = 32'h1234; held_pc = 32'h300;
    chk("hold_pre_a", rr_if.a, held_a);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      v = dflt(); v.rs1 = 5'd11; apply(v); hold = 1'b1; id_pc = 32'h400 + 32'(c);
      #1;
      chk($sformatf("hold%0d_stall", c), 32'(stall), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_a", c), rr_if.a, held_a);
      chk($sformatf("hold%0d_pc", c), rr_if.pc, held_pc);
      $display("hold %0d: stall=%0d a=0x%08h pc=0x%08h", c, stall, rr_if.a, rr_if.pc);
      @(negedge clk);
    end

    // Flush beats hold and load-use
    v = dflt(); v.rs2 = 5'd9; v.ex_rd = 5'd9; v.ex_w = 1; v.ex_ld = 1; v.ex_bub = 0;
    apply(v); hold = 1'b1; flush = 1'b1; id_pc = 32'h500; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("flush_bubble", 32'(rr_if.bubble), 32'd1);
    chk("flush_w_rd", 32'(rr_if.w_rd), 32'd0);
    chk("flush_w_cr", 32'(rr_if.w_cr), 32'd0);
    $display("flush: stall=0 bubble=%0d", rr_if.bubble);
    @(negedge clk);

    // Reset mid-stream after a valid latch
    v = dflt(); v.rs1 = 5'd3; v.cmp = 2'b11; apply(v); id_pc = 32'h600;
    @(posedge clk); #1;
    chk("prerst_a", rr_if.a, 32'h1234);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_bubble", 32'(rr_if.bubble), 32'd1);
    chk("rst_a", rr_if.a, 32'd0);
    chk("rst_b", rr_if.b, 32'd0);
    chk("rst_pc", rr_if.pc, 32'd0);
    chk("rst_cr", 32'(rr_if.cr), 32'd0);
    chk("rst_rd", 32'(rr_if.rd), 32'd0);
    chk("rst_w", 32'({rr_if.w_rd, rr_if.w_cr, rr_if.is_load}), 32'd0);
    $display("mid reset: bubble=%0d a=0x%08h pc=0x%08h", rr_if.bubble, rr_if.a, rr_if.pc);
    @(negedge clk);
    rst = 1'b0; apply(dflt()); id_pc = 32'h700; #1;
    chk("postrst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("postrst_a", rr_if.a, 32'h1001);
    chk("postrst_bubble", 32'(rr_if.bubble), 32'd0);
    $display("post reset: stall=%0d a=0x%08h", stall, rr_if.a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
